// File: rtl/err_inject_pkg.sv
// Shared constants and helpers for the 8b/10b link bit-error injector.
package err_inject_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_RANDOM  = 2'd1,
    MODE_BURST   = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_e;

  localparam int              LFSR_W    = 32;
  // Taps for x^32 + x^22 + x^2 + x^1: state bits 31, 21, 1 and 0.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [LFSR_W-1:0] SEED_XOR  = 32'hA5A5_5A5A;
  localparam int              PC_W      = 9;

  function automatic logic [PC_W-1:0] popcount(input logic [255:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < 256; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Fibonacci LFSR with seed load; an all-zero load is forced to 1 so it can never lock up.
module lfsr32
  import err_inject_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              adv,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (load_val == '0) ? LFSR_W'(1) : load_val;
    end else if (adv) begin
      q_d = {q_q[LFSR_W-2:0], ^(q_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= LFSR_W'(1);
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/err_inject_ctrl.sv
// Deterministic bit-error injector between the 8b/10b encoder and decoder: random, burst and
// one-shot corruption with a one-cycle pipeline and saturating injection statistics.
module err_inject_ctrl
  import err_inject_pkg::*;
#(
  parameter int DATA_W    = 80,
  parameter int MAX_FLIPS = 4,
  parameter int RATE_W    = 16,
  parameter int BURST_W   = 6,
  parameter int CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_en,
  input  logic [1:0]         cfg_mode,
  input  logic [RATE_W-1:0]  cfg_rate,
  input  logic [2:0]         cfg_nflips,
  input  logic [BURST_W-1:0] cfg_burst_len,
  input  logic [31:0]        seed,
  input  logic               seed_load,
  input  logic               inj_trig,
  input  logic               cnt_clr,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  din,
  output logic               out_valid,
  output logic [DATA_W-1:0]  dout,
  output logic [DATA_W-1:0]  err_mask,
  output logic               armed,
  output logic [CNT_W-1:0]   inj_cnt,
  output logic [CNT_W-1:0]   flip_cnt
);

  localparam int               SUM_W   = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [LFSR_W-1:0] d_val, p_val;
  logic              adv;

  assign adv = in_valid && cfg_en;

  lfsr32 u_lfsr_d (
    .clk      (clk),
    .rst      (rst),
    .load     (seed_load),
    .load_val (seed ^ SEED_XOR),
    .adv      (adv),
    .q        (d_val)
  );

  lfsr32 u_lfsr_p (
    .clk      (clk),
    .rst      (rst),
    .load     (seed_load),
    .load_val (seed),
    .adv      (adv),
    .q        (p_val)
  );

  logic unused_d;
  assign unused_d = ^d_val;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] err_mask_q, err_mask_d;
  logic              armed_q, armed_d;
  logic [CNT_W-1:0]  inj_cnt_q, inj_cnt_d;
  logic [CNT_W-1:0]  flip_cnt_q, flip_cnt_d;

  int                pos [4];
  int                nf;
  int                bl;
  int                off;
  logic              hit;
  logic [DATA_W-1:0] rand_m, burst_m, mask_d;
  logic [PC_W-1:0]   flip_pc;
  logic [SUM_W-1:0]  flip_sum;

  always_comb begin
    // Scaling an 8-bit slice by DATA_W/256 lands inside the beat without a modulo.
    for (int k = 0; k < 4; k++) pos[k] = int'(32'(p_val[8*k +: 8])) * DATA_W / 256;

    nf = int'({29'd0, cfg_nflips});
    if (nf < 1)         nf = 1;
    if (nf > MAX_FLIPS) nf = MAX_FLIPS;

    bl = int'({{(32-BURST_W){1'b0}}, cfg_burst_len});
    if (bl < 1)      bl = 1;
    if (bl > DATA_W) bl = DATA_W;

    rand_m  = '0;
    burst_m = '0;
    off     = 0;
    for (int i = 0; i < DATA_W; i++) begin
      for (int k = 0; k < MAX_FLIPS; k++) begin
        if (k < nf && pos[k] == i) rand_m[i] = 1'b1;
      end
      off        = (i >= pos[0]) ? (i - pos[0]) : (i + DATA_W - pos[0]);
      burst_m[i] = (off < bl);
    end

    hit    = adv && (d_val[RATE_W-1:0] < cfg_rate);
    mask_d = '0;
    case (mode_e'(cfg_mode))
      MODE_RANDOM:  if (hit) mask_d = rand_m;
      MODE_BURST:   if (hit) mask_d = burst_m;
      MODE_ONESHOT: if (adv && armed_q) mask_d = burst_m;
      default:      mask_d = '0;
    endcase

    // A trigger that lands on the consuming beat re-arms for exactly one more shot.
    if (mode_e'(cfg_mode) != MODE_ONESHOT) armed_d = 1'b0;
    else if (inj_trig)                     armed_d = 1'b1;
    else if (adv && armed_q)               armed_d = 1'b0;
    else                                   armed_d = armed_q;

    out_valid_d = in_valid;
    dout_d      = in_valid ? (din ^ mask_d) : dout_q;
    err_mask_d  = in_valid ? mask_d : err_mask_q;

    flip_pc    = popcount(256'(mask_d));
    flip_sum   = '0;
    inj_cnt_d  = inj_cnt_q;
    flip_cnt_d = flip_cnt_q;
    if (cnt_clr) begin
      inj_cnt_d  = '0;
      flip_cnt_d = '0;
    end else if (mask_d != '0) begin
      if (inj_cnt_q != CNT_MAX) inj_cnt_d = inj_cnt_q + CNT_W'(1);
      flip_sum   = SUM_W'(flip_cnt_q) + SUM_W'(flip_pc);
      flip_cnt_d = (flip_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : flip_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      err_mask_q  <= '0;
      armed_q     <= 1'b0;
      inj_cnt_q   <= '0;
      flip_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      err_mask_q  <= err_mask_d;
      armed_q     <= armed_d;
      inj_cnt_q   <= inj_cnt_d;
      flip_cnt_q  <= flip_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign err_mask  = err_mask_q;
  assign armed     = armed_q;
  assign inj_cnt   = inj_cnt_q;
  assign flip_cnt  = flip_cnt_q;

endmodule

// File: tb/tb_err_inject_ctrl.sv
// Bench for err_inject_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_err_inject_ctrl;

  localparam int DW = 80;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_en = 1'b0;
  logic [1:0]    cfg_mode = 2'd0;
  logic [15:0]   cfg_rate = 16'd0;
  logic [2:0]    cfg_nflips = 3'd0;
  logic [5:0]    cfg_burst_len = 6'd0;
  logic [31:0]   seed = 32'd0;
  logic          seed_load = 1'b0;
  logic          inj_trig = 1'b0;
  logic          cnt_clr = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] din = '0;

  logic          out_valid, armed;
  logic [DW-1:0] dout, err_mask;
  logic [31:0]   inj_cnt, flip_cnt;
  logic          s_out_valid, s_armed;
  logic [DW-1:0] s_dout, s_err_mask;
  logic [3:0]    s_inj_cnt, s_flip_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  err_inject_ctrl dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_rate(cfg_rate),
    .cfg_nflips(cfg_nflips), .cfg_burst_len(cfg_burst_len), .seed(seed), .seed_load(seed_load),
    .inj_trig(inj_trig), .cnt_clr(cnt_clr), .in_valid(in_valid), .din(din),
    .out_valid(out_valid), .dout(dout), .err_mask(err_mask), .armed(armed),
    .inj_cnt(inj_cnt), .flip_cnt(flip_cnt)
  );

  err_inject_ctrl #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_rate(cfg_rate),
    .cfg_nflips(cfg_nflips), .cfg_burst_len(cfg_burst_len), .seed(seed), .seed_load(seed_load),
    .inj_trig(inj_trig), .cnt_clr(cnt_clr), .in_valid(in_valid), .din(din),
    .out_valid(s_out_valid), .dout(s_dout), .err_mask(s_err_mask), .armed(s_armed),
    .inj_cnt(s_inj_cnt), .flip_cnt(s_flip_cnt)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] lstep(input logic [31:0] q);
    return {q[30:0], q[31] ^ q[21] ^ q[1] ^ q[0]};
  endfunction

  function automatic logic [31:0] lload(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

  function automatic int pos_of(input logic [31:0] p, input int k);
    return int'((p >> (8 * k)) & 32'hFF) * DW / 256;
  endfunction

  function automatic logic [DW-1:0] burst_mask(input int p0, input int len);
    logic [DW-1:0] r;
    r = '0;
    for (int j = 0; j < len; j++) r = r | (DW'(1) << ((p0 + j) % DW));
    return r;
  endfunction

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  logic [31:0]   m_d, m_p;
  logic          m_armed, m_ov;
  logic [DW-1:0] m_dout, m_mask;
  logic [31:0]   m_inj, m_flip;
  logic [3:0]    m_inj4, m_flip4;

  logic [DW-1:0] mdl_mk;
  int            mdl_nf, mdl_bl, mdl_pc;
  logic          mdl_hit;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_d <= 32'd1; m_p <= 32'd1; m_armed <= 1'b0; m_ov <= 1'b0;
      m_dout <= '0; m_mask <= '0;
      m_inj <= '0; m_flip <= '0; m_inj4 <= '0; m_flip4 <= '0;
    end else begin
      mdl_nf = int'(cfg_nflips);
      if (mdl_nf == 0) mdl_nf = 1;
      if (mdl_nf > 4)  mdl_nf = 4;
      mdl_bl = int'(cfg_burst_len);
      if (mdl_bl == 0) mdl_bl = 1;
      if (mdl_bl > DW) mdl_bl = DW;
      mdl_mk  = '0;
      mdl_hit = (m_d[15:0] < cfg_rate);
      if (cfg_en && in_valid) begin
        if (cfg_mode == 2'd1 && mdl_hit) begin
          for (int k = 0; k < mdl_nf; k++) mdl_mk = mdl_mk | (DW'(1) << pos_of(m_p, k));
        end else if (cfg_mode == 2'd2 && mdl_hit) begin
          mdl_mk = burst_mask(pos_of(m_p, 0), mdl_bl);
        end else if (cfg_mode == 2'd3 && m_armed) begin
          mdl_mk = burst_mask(pos_of(m_p, 0), mdl_bl);
        end
      end
      if (cfg_mode != 2'd3)               m_armed <= 1'b0;
      else if (inj_trig)                  m_armed <= 1'b1;
      else if (cfg_en && in_valid)        m_armed <= 1'b0;

      if (seed_load) begin
        m_d <= lload(seed ^ 32'hA5A5_5A5A);
        m_p <= lload(seed);
      end else if (cfg_en && in_valid) begin
        m_d <= lstep(m_d);
        m_p <= lstep(m_p);
      end

      m_ov <= in_valid;
      if (in_valid) begin
        m_dout <= din ^ mdl_mk;
        m_mask <= mdl_mk;
      end

      mdl_pc = $countones(mdl_mk);
      if (cnt_clr) begin
        m_inj <= '0; m_flip <= '0; m_inj4 <= '0; m_flip4 <= '0;
      end else if (mdl_mk != '0) begin
        m_inj   <= 32'(sat(longint'(m_inj) + 1, 64'hFFFF_FFFF));
        m_flip  <= 32'(sat(longint'(m_flip) + mdl_pc, 64'hFFFF_FFFF));
        m_inj4  <= 4'(sat(longint'(m_inj4) + 1, 15));
        m_flip4 <= 4'(sat(longint'(m_flip4) + mdl_pc, 15));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", 128'(out_valid), 128'(m_ov));
      chk("dout", 128'(dout), 128'(m_dout));
      chk("err_mask", 128'(err_mask), 128'(m_mask));
      chk("armed", 128'(armed), 128'(m_armed));
      chk("inj_cnt", 128'(inj_cnt), 128'(m_inj));
      chk("flip_cnt", 128'(flip_cnt), 128'(m_flip));
      chk("inj_cnt4", 128'(s_inj_cnt), 128'(m_inj4));
      chk("flip_cnt4", 128'(s_flip_cnt), 128'(m_flip4));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    seed_load = 1'b0;
    inj_trig  = 1'b0;
    cnt_clr   = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #20 rst = 1'b0;
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_dout", 128'(dout), 128'd0);
    chk("rst_err_mask", 128'(err_mask), 128'd0);
    chk("rst_armed", 128'(armed), 128'd0);
    chk("rst_inj_cnt", 128'(inj_cnt), 128'd0);
    chk("rst_flip_cnt", 128'(flip_cnt), 128'd0);

    // bypass
    cfg_en = 1'b0; cfg_mode = 2'd1; cfg_rate = 16'hFFFF; cfg_nflips = 3'd1;
    in_valid = 1'b1; din = 80'h1234_5678_9ABC_DEF0_1357;
    tick();
    chk("bypass_dout", 128'(dout), 128'h1234_5678_9ABC_DEF0_1357);
    chk("bypass_mask", 128'(err_mask), 128'd0);
    chk("bypass_inj", 128'(inj_cnt), 128'd0);
    in_valid = 1'b0;

    // random single flip, replayed from the same seed
    for (int rep = 0; rep < 2; rep++) begin
      cfg_en = 1'b1; seed = 32'h0000_0080; seed_load = 1'b1; cnt_clr = 1'b1; in_valid = 1'b0;
      tick();
      in_valid = 1'b1; din = '0;
      tick();
      chk("rand1_mask", 128'(err_mask), 128'(DW'(1) << 40));
      chk("rand1_dout", 128'(dout), 128'(DW'(1) << 40));
      chk("rand1_inj", 128'(inj_cnt), 128'd1);
      chk("rand1_flip", 128'(flip_cnt), 128'd1);
      for (int b = 0; b < 6; b++) begin
        din = {$urandom(), $urandom(), 16'($urandom())};
        tick();
      end
      in_valid = 1'b0;
    end

    // burst wrapping past bit 79
    cfg_mode = 2'd2; cfg_burst_len = 6'd3; seed = 32'h0000_00FF; seed_load = 1'b1; cnt_clr = 1'b1;
    tick();
    in_valid = 1'b1;
    tick();
    chk("burst_wrap_mask", 128'(err_mask), 128'((DW'(1) << 79) | DW'(3)));
    chk("burst_wrap_flip", 128'(flip_cnt), 128'd3);
    in_valid = 1'b0;

    // one-shot
    cfg_mode = 2'd3; cnt_clr = 1'b1;
    tick();
    inj_trig = 1'b1;
    tick();
    chk("oneshot_armed", 128'(armed), 128'd1);
    in_valid = 1'b1;
    for (int b = 0; b < 5; b++) begin
      din = {$urandom(), $urandom(), 16'($urandom())};
      tick();
      chk("oneshot_hit", 128'(err_mask != '0), (b == 0) ? 128'd1 : 128'd0);
      chk("oneshot_disarm", 128'(armed), 128'd0);
    end
    chk("oneshot_inj1", 128'(inj_cnt), 128'd1);
    in_valid = 1'b0; cnt_clr = 1'b1; inj_trig = 1'b1;
    tick();
    in_valid = 1'b1; inj_trig = 1'b1;
    tick();
    chk("oneshot_coinc_hit", 128'(err_mask != '0), 128'd1);
    chk("oneshot_coinc_armed", 128'(armed), 128'd1);
    tick();
    chk("oneshot_second_hit", 128'(err_mask != '0), 128'd1);
    chk("oneshot_second_armed", 128'(armed), 128'd0);
    tick();
    chk("oneshot_after", 128'(err_mask), 128'd0);
    chk("oneshot_inj2", 128'(inj_cnt), 128'd2);
    in_valid = 1'b0;

    // saturation and clear
    cfg_mode = 2'd1; cfg_rate = 16'hFFFF; cfg_nflips = 3'd4; cnt_clr = 1'b1;
    tick();
    in_valid = 1'b1;
    repeat (20) tick();
    chk("sat_inj4", 128'(s_inj_cnt), 128'd15);
    chk("sat_flip4", 128'(s_flip_cnt), 128'd15);
    cnt_clr = 1'b1;
    tick();
    chk("clr_inj", 128'(inj_cnt), 128'd0);
    chk("clr_flip", 128'(flip_cnt), 128'd0);
    chk("clr_inj4", 128'(s_inj_cnt), 128'd0);

    // async reset mid-stream
    cfg_nflips = 3'd1; din = {80{1'b1}};
    tick();
    cfg_mode = 2'd3; inj_trig = 1'b1; in_valid = 1'b0;
    tick();
    chk("pre_rst_armed", 128'(armed), 128'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'd0);
    chk("arst_dout", 128'(dout), 128'd0);
    chk("arst_err_mask", 128'(err_mask), 128'd0);
    chk("arst_armed", 128'(armed), 128'd0);
    @(negedge clk) rst = 1'b0;
    cfg_mode = 2'd1; cfg_rate = 16'hFFFF; in_valid = 1'b1; din = '0;
    tick();
    chk("post_rst_mask", 128'(err_mask), 128'd1);
    chk("post_rst_dout", 128'(dout), 128'd1);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      din = {$urandom(), $urandom(), 16'($urandom())};
      if ($urandom_range(0, 19) == 0) begin
        cfg_en = ($urandom_range(0, 7) != 0);
        cfg_mode = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0: cfg_rate = 16'h0000;
          1: cfg_rate = 16'hFFFF;
          default: cfg_rate = 16'($urandom());
        endcase
        cfg_nflips = 3'($urandom_range(0, 7));
        cfg_burst_len = 6'($urandom_range(0, 63));
      end
      inj_trig = ($urandom_range(0, 9) == 0);
      cnt_clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 59) == 0) begin
        seed_load = 1'b1;
        case ($urandom_range(0, 3))
          0: seed = 32'h0;
          1: seed = 32'hA5A5_5A5A;
          default: seed = $urandom();
        endcase
      end
      tick();
    end

    in_valid = 1'b0;
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
